// File: rtl/universal_shift_register.sv
// Universal shift register: synchronous parallel load, serial shift left or
// right, and a synchronous clear. Bit 0 is the leftmost bit (MSB) and every
// vector is declared [0:WIDTH-1]. SERIAL_OUT is the bit that leaves the
// register on the next shift in the currently selected direction.
module universal_shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,             // asynchronous, active-low
    input  logic             CLR,             // synchronous, active-low
    input  logic             PARALLEL_MODE,   // 1 = load, 0 = shift
    input  logic             SI,
    input  logic             SR,              // 1 = shift right, 0 = shift left
    input  logic [0:WIDTH-1] PARALLEL_INPUT,
    output logic             SERIAL_OUT,
    output logic [0:WIDTH-1] PARALLEL_OUT
);

    logic [0:WIDTH-1] q_q;
    logic [0:WIDTH-1] q_d;

    // Next-state selection in priority order: clear, load, shift left, shift right.
    always_comb begin
        // NOTE: assign a default first so every path drives q_d and no latch is inferred.
        q_d = q_q;
        if (!CLR) begin
            q_d = '0;
        end else if (PARALLEL_MODE) begin
            q_d = PARALLEL_INPUT;
        end else if (!SR) begin
            // Left: bits move toward index 0; SI enters at the right end.
            q_d = {q_q[1:WIDTH-1], SI};
        end else begin
            // Right: bits move toward index WIDTH-1; SI enters at the left end.
            q_d = {SI, q_q[0:WIDTH-2]};
        end
    end

    // State register; reset clears it immediately, independent of the clock.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Outgoing bit follows SR within the same cycle.
    assign SERIAL_OUT   = SR ? q_q[WIDTH-1] : q_q[0];
    assign PARALLEL_OUT = q_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed test of universal_shift_register (WIDTH=4). Vectors are written
// bit0..bit3, which matches the [0:3] declaration of 4'b literals.
module tb_universal_shift_register;

    logic       CLK;
    logic       RST;
    logic       CLR;
    logic       PARALLEL_MODE;
    logic       SI;
    logic       SR;
    logic [0:3] PARALLEL_INPUT;
    logic       SERIAL_OUT;
    logic [0:3] PARALLEL_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    universal_shift_register #(.WIDTH(4)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .CLR            (CLR),
        .PARALLEL_MODE  (PARALLEL_MODE),
        .SI             (SI),
        .SR             (SR),
        .PARALLEL_INPUT (PARALLEL_INPUT),
        .SERIAL_OUT     (SERIAL_OUT),
        .PARALLEL_OUT   (PARALLEL_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_q(input string tag, input logic [0:3] exp);
        n_checks++;
        assert (PARALLEL_OUT === exp)
        else begin
            n_fail++;
            $error("FAIL %s: PARALLEL_OUT observed %b expected %b", tag, PARALLEL_OUT, exp);
        end
    endtask

    task automatic chk_so(input string tag, input logic exp);
        n_checks++;
        assert (SERIAL_OUT === exp)
        else begin
            n_fail++;
            $error("FAIL %s: SERIAL_OUT observed %b expected %b", tag, SERIAL_OUT, exp);
        end
    endtask

    initial begin
        RST            = 1'b1;
        CLR            = 1'b1;
        PARALLEL_MODE  = 1'b1;
        SI             = 1'b1;
        SR             = 1'b0;
        PARALLEL_INPUT = 4'b1111;

        // Load something non-zero so reset has an effect to show.
        tick();
        chk_q("preload", 4'b1111);

        // 1. Asynchronous reset between edges, held across edges, then release.
        #1 RST = 1'b0;
        #1;
        chk_q("rst_async_q", 4'b0000);
        chk_so("rst_async_so", 1'b0);
        tick();
        chk_q("rst_held_q", 4'b0000);
        PARALLEL_INPUT = 4'b1010;
        #1 RST = 1'b1;
        #1;
        chk_q("rst_release_nochange", 4'b0000);

        // 2. Parallel load, then SERIAL_OUT follows SR combinationally.
        tick();
        chk_q("load_1010", 4'b1010);
        chk_so("load_so_left", 1'b1);
        SR = 1'b1;
        #1;
        chk_so("load_so_right", 1'b0);

        // 3. Shift left with SI=1, then SI=0.
        PARALLEL_MODE = 1'b0;
        SR            = 1'b0;
        SI            = 1'b1;
        tick(); chk_q("left1_a", 4'b0101); chk_so("left1_a_so", 1'b0);
        tick(); chk_q("left1_b", 4'b1011); chk_so("left1_b_so", 1'b1);
        tick(); chk_q("left1_c", 4'b0111); chk_so("left1_c_so", 1'b0);
        tick(); chk_q("left1_d", 4'b1111); chk_so("left1_d_so", 1'b1);
        SI = 1'b0;
        tick(); chk_q("left0_a", 4'b1110);
        tick(); chk_q("left0_b", 4'b1100);
        tick(); chk_q("left0_c", 4'b1000);
        tick(); chk_q("left0_d", 4'b0000);

        // 4. Shift right with SI=1; SERIAL_OUT tracks Q[3].
        SR = 1'b1;
        SI = 1'b1;
        tick(); chk_q("right_a", 4'b1000); chk_so("right_a_so", 1'b0);
        tick(); chk_q("right_b", 4'b1100); chk_so("right_b_so", 1'b0);
        tick(); chk_q("right_c", 4'b1110); chk_so("right_c_so", 1'b0);
        tick(); chk_q("right_d", 4'b1111); chk_so("right_d_so", 1'b1);

        // 5. Clear beats load; nothing changes before the edge.
        CLR            = 1'b0;
        PARALLEL_MODE  = 1'b1;
        PARALLEL_INPUT = 4'b0110;
        #1;
        chk_q("clr_before_edge", 4'b1111);
        tick();
        chk_q("clr_beats_load", 4'b0000);
        CLR = 1'b1;
        tick();
        chk_q("load_0110", 4'b0110);

        // Clear also beats a shift.
        PARALLEL_MODE = 1'b0;
        CLR           = 1'b0;
        tick();
        chk_q("clr_beats_shift", 4'b0000);
        CLR = 1'b1;
        PARALLEL_MODE = 1'b1;
        tick();
        chk_q("reload_0110", 4'b0110);

        // 6. Reset pulse during a right shift; shifting resumes from zero.
        PARALLEL_MODE = 1'b0;
        SR            = 1'b1;
        SI            = 1'b1;
        tick();
        chk_q("right_from_0110", 4'b1011);
        chk_so("right_from_0110_so", 1'b1);
        #1 RST = 1'b0;
        #1;
        chk_q("rst_pulse_q", 4'b0000);
        chk_so("rst_pulse_so", 1'b0);
        #1 RST = 1'b1;
        #1;
        chk_q("rst_pulse_release", 4'b0000);
        tick();
        chk_q("resume_a", 4'b1000);
        SI = 1'b0;
        tick();
        chk_q("resume_b", 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
